ram_fifo_ctrl: RTL
==================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, data word width, matching the ram data ports.
REQ-002 SHALL have parameter A_WIDTH, default 5, ram address width; depth = 2**A_WIDTH (32).
REQ-003 SHALL have parameter AF_LEVEL, default 28, almost-full threshold in entries.
REQ-004 SHALL have port clk, input, 1, the single clock; it drives both ram clk_write and clk_read.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, producer offers in_data.
REQ-007 SHALL have port in_ready, output, 1, controller can accept a word.
REQ-008 SHALL have port in_data, input, D_WIDTH, write word.
REQ-009 SHALL have port out_pop, input, 1, consumer requests one word.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a popped word this cycle.
REQ-011 SHALL have port out_data, output, D_WIDTH, popped word.
REQ-012 SHALL have port ram_address_write, output, A_WIDTH, to ram address_write.
REQ-013 SHALL have port ram_data_write, output, D_WIDTH, to ram data_write.
REQ-014 SHALL have port ram_write_enable, output, 1, to ram write_enable.
REQ-015 SHALL have port ram_address_read, output, A_WIDTH, to ram address_read.
REQ-016 SHALL have port ram_data_read, input, D_WIDTH, from ram data_read.
REQ-017 SHALL have port count, output, A_WIDTH+1, stored entries, 0..2**A_WIDTH.
REQ-018 SHALL have ports full, empty, almost_full, output, 1 each, occupancy flags.
REQ-019 SHALL have ports overflow_err, underflow_err, output, 1 each, sticky error flags.

Function
REQ-020 SHALL define push = in_valid & in_ready, with in_ready = !full & !rst (combinational).
REQ-021 SHALL define pop = out_pop & !empty & !rst (combinational).
REQ-022 SHALL drive ram_write_enable = push, ram_address_write = wr_ptr, ram_data_write = in_data, all combinational.
REQ-023 SHALL drive ram_address_read = rd_ptr combinationally; the ram samples it every edge.
REQ-024 SHALL advance wr_ptr by 1 on each push and rd_ptr by 1 on each pop, modulo 2**A_WIDTH (31 wraps to 0).
REQ-025 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-026 SHALL derive full = (count == 2**A_WIDTH), empty = (count == 0), almost_full = (count >= AF_LEVEL), all from registered count.
REQ-027 SHALL register out_valid = pop, giving 1-cycle pop-to-data latency matching ram read latency.
REQ-028 SHALL pass out_data = ram_data_read unmodified; out_data is meaningful only while out_valid = 1.
REQ-029 SHALL, on simultaneous push and pop while full, reject the push (in_ready = 0), perform the pop, leaving count = 2**A_WIDTH-1.
REQ-030 SHALL, on simultaneous push and pop while empty, reject the pop, perform the push, leaving count = 1, out_valid = 0 next cycle.
REQ-031 SHALL allow a word pushed at edge N to be popped from cycle N+1 onward; the ram returns that word at out_data in cycle N+2.
REQ-032 SHALL support back-to-back pops with one word per cycle, out_valid held high continuously.
REQ-033 SHALL set overflow_err when in_valid & full & !rst, and underflow_err when out_pop & empty & !rst; both stay set until reset.

Reset
REQ-034 SHALL, at a clk edge with rst = 1, clear wr_ptr, rd_ptr, count, out_valid, overflow_err, underflow_err to 0, giving empty = 1, full = 0, almost_full = 0.
REQ-035 SHALL hold ram_write_enable = 0 and ignore out_pop while rst = 1; a pop issued in the cycle before reset SHALL NOT assert out_valid after reset.
REQ-036 SHALL NOT clear ram contents; stale data SHALL be unreachable after reset.

Verification
REQ-037 SHALL verify: reset, push 0x0001..0x0003, then pop 3 -> out_valid on 3 consecutive cycles, out_data 0x0001, 0x0002, 0x0003, count 0, empty 1.
REQ-038 SHALL verify: push 32 words -> full 1, in_ready 0, almost_full set at count 28; 33rd in_valid -> word dropped, overflow_err 1.
REQ-039 SHALL verify: fill 32, pop 1 and push 0xBEEF same cycle -> pop performed, push rejected, count 31.
REQ-040 SHALL verify: 40 push/pop pairs with one in flight -> wr_ptr/rd_ptr wrap 31->0, data order intact, count stays 1.
REQ-041 SHALL verify: out_pop while empty -> out_valid 0, underflow_err 1, count 0.
REQ-042 SHALL verify: rst asserted mid-burst with count 10 -> next cycle count 0, empty 1, out_valid 0, errors 0; push 0x1234 then pop -> out_data 0x1234.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO control logic for an external synchronous dual-port RAM.
// The controller tracks the write/read pointers and the occupancy, and drives the RAM
// write port directly from the producer handshake. The RAM has a one-cycle registered
// read, so out_valid is the pop delayed by one cycle and out_data is taken straight
// from the RAM read port.
module ram_fifo_ctrl #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 5,
    parameter int AF_LEVEL = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    // producer side
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   in_data,
    // consumer side
    input  logic                 out_pop,
    output logic                 out_valid,
    output logic [D_WIDTH-1:0]   out_data,
    // RAM write port
    output logic [A_WIDTH-1:0]   ram_address_write,
    output logic [D_WIDTH-1:0]   ram_data_write,
    output logic                 ram_write_enable,
    // RAM read port
    output logic [A_WIDTH-1:0]   ram_address_read,
    input  logic [D_WIDTH-1:0]   ram_data_read,
    // status
    output logic [A_WIDTH:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    // Occupancy constants sized to the count register.
    localparam logic [A_WIDTH:0] DEPTH    = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH:0] AF_LVL   = AF_LEVEL[A_WIDTH:0];

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   count_q,  count_d;
    logic               out_valid_q, out_valid_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic               push;
    logic               pop;
    logic               full_w;
    logic               empty_w;

    // Handshake qualification: reset blocks both directions, full blocks push, empty blocks pop.
    always_comb begin
        full_w   = (count_q == DEPTH);
        empty_w  = (count_q == '0);
        in_ready = !full_w && !rst;
        push     = in_valid && in_ready;
        pop      = out_pop && !empty_w && !rst;
    end

    // Next-state for pointers, occupancy, read-valid pipeline and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = pop;
        ovf_d       = ovf_q | (in_valid && full_w && !rst);
        udf_d       = udf_q | (out_pop && empty_w && !rst);

        // Pointers wrap naturally at 2**A_WIDTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; RAM contents are left untouched since
    // resetting both pointers makes any stale words unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Output drive: RAM ports follow the pointers and handshake, flags follow the registered count.
    always_comb begin
        ram_write_enable  = push;
        ram_address_write = wr_ptr_q;
        ram_data_write    = in_data;
        ram_address_read  = rd_ptr_q;
        out_valid         = out_valid_q;
        out_data          = ram_data_read;
        count             = count_q;
        full              = full_w;
        empty             = empty_w;
        almost_full       = (count_q >= AF_LVL);
        overflow_err      = ovf_q;
        underflow_err     = udf_q;
    end

endmodule
